// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feed_ctrl
//  Description : Job sequencer for an N x N systolic MAC array. Accepts a
//                streamed matrix-product job (K operand beats), forwards
//                unskewed operand vectors to the array, generates the per-PE
//                en/clr grids matching the array's i+j skew, then captures
//                the N x N results and drains them row-major over a
//                valid/ready port.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                start, k_len, busy      - job request / inner length / busy
//                op_valid/op_ready/op_a/op_w - operand beat stream
//                a_out, w_out            - operand vectors to the array
//                en_/clr_mult, en_/clr_accum - per-PE control, bit i*N+j
//                c_in                    - array results, PE(i,j) at (i*N+j)*DW
//                res_valid/res_ready/res_data/res_idx - result stream
//                done                    - one-cycle pulse after last result
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_ctrl #(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int KW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    output logic                   busy,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [N*DW-1:0]        op_a,
    input  logic [N*DW-1:0]        op_w,
    output logic [N*DW-1:0]        a_out,
    output logic [N*DW-1:0]        w_out,
    output logic [N*N-1:0]         en_mult,
    output logic [N*N-1:0]         clr_mult,
    output logic [N*N-1:0]         en_accum,
    output logic [N*N-1:0]         clr_accum,
    input  logic [N*N*DW-1:0]      c_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DW-1:0]          res_data,
    output logic [2*$clog2(N)-1:0] res_idx,
    output logic                   done
);

    localparam int              C_IW   = $clog2(N);
    localparam logic [C_IW-1:0] C_LAST = C_IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [KW-1:0]       cnt_q, cnt_d;
    logic [2*N-1:1]      vsr_q;
    logic [2*N-2:0]      vsr_d;
    logic [N*N*DW-1:0]   cbuf_q, cbuf_d;
    logic [C_IW-1:0]     ri_q, ri_d, rj_q, rj_d;
    logic                busy_q, busy_d;
    logic                op_ready_q, op_ready_d;
    logic                res_valid_q, res_valid_d;
    logic                done_q, done_d;

    logic                w_fire;
    logic                w_clr;
    logic [2*N-1:0]      w_vsr;

    // Stage 0 of the valid pipeline is the accept itself, so PE(0,0)
    // multiplies in the same cycle the operands appear on a_out/w_out.
    assign w_fire = op_valid & op_ready_q;
    assign w_vsr  = {vsr_q, w_fire};
    assign vsr_d  = w_vsr[2*N-2:0];

    // Non-accept cycles present zero bubbles so stale data never enters.
    assign a_out  = w_fire ? op_a : '0;
    assign w_out  = w_fire ? op_w : '0;

    assign clr_mult  = {(N*N){w_clr}};
    assign clr_accum = {(N*N){w_clr}};

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign en_mult[i*N+j]  = w_vsr[i+j];
            assign en_accum[i*N+j] = w_vsr[i+j+1];
        end
    end

    assign busy      = busy_q;
    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign done      = done_q;
    assign res_idx   = {ri_q, rj_q};

    always_comb begin
        res_data = '0;
        for (int p = 0; p < N*N; p++) begin
            if (p == int'(ri_q) * N + int'(rj_q)) begin
                res_data = cbuf_q[p*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        cbuf_d  = cbuf_q;
        ri_d    = ri_q;
        rj_d    = rj_q;
        done_d  = 1'b0;
        w_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    cnt_d   = '0;
                    ri_d    = '0;
                    rj_d    = '0;
                    w_clr   = 1'b1;
                    state_d = (k_len != '0) ? S_FEED : S_WAIT;
                end
            end
            S_FEED: begin
                if (w_fire) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q == k_q - KW'(1)) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Hold until the last beat has walked through every PE.
                if (w_vsr == '0) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cbuf_d  = c_in;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (res_ready) begin
                    if (rj_q == C_LAST) begin
                        rj_d = '0;
                        if (ri_q == C_LAST) begin
                            ri_d    = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ri_d = ri_q + C_IW'(1);
                        end
                    end else begin
                        rj_d = rj_q + C_IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        op_ready_d  = (state_d == S_FEED);
        res_valid_d = (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            vsr_q       <= '0;
            cbuf_q      <= '0;
            ri_q        <= '0;
            rj_q        <= '0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            vsr_q       <= vsr_d;
            cbuf_q      <= cbuf_d;
            ri_q        <= ri_d;
            rj_q        <= rj_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer that drives an N×N systolic MAC array. It accepts a streamed matrix product job, feeds unskewed operand vectors to the array's a/w inputs, and generates the per-PE en/clr control grids.
- When the job completes it captures the array's N×N results and drains them row-major over a valid/ready result port.
- Sits between the operand buffer and the systolic array; it is the driver end of the array's a_in_raw/w_in_raw/en_*/clr_* interface.

Parameters:
- N, 2, array dimension (matches `N).
- DW, 32, data width of operands and results.
- KW, 16, width of the inner-dimension length K.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  inner dimension K, sampled with start.
- busy  out  1  high in every state except IDLE.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  operand beat accepted when op_valid&op_ready ("fire").
- op_a  in  N*DW  column k of A; element i at [i*DW +: DW].
- op_w  in  N*DW  row k of W; element j at [j*DW +: DW].
- a_out  out  N*DW  to array a_in_raw; element i at [i*DW +: DW].
- w_out  out  N*DW  to array w_in_raw; element j at [j*DW +: DW].
- en_mult  out  N*N  bit i*N+j drives PE(i,j).
- clr_mult  out  N*N  same mapping.
- en_accum  out  N*N  same mapping.
- clr_accum  out  N*N  same mapping.
- c_in  in  N*N*DW  array results; PE(i,j) at [(i*N+j)*DW +: DW].
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accepted.
- res_data  out  DW  result value.
- res_idx  out  2*clog2(N)  {i,j} of the current result.
- done  out  1  one-cycle pulse after the last result beat.

Behaviour:
- States: IDLE, FEED, WAIT, CAPTURE, DRAIN.
- Reset: state IDLE; valid shift register vsr, counters and capture buffer are 0. All outputs are 0, including op_ready, busy, res_valid and done.
- IDLE:
  - If start=1: latch k_len and drive clr_mult=clr_accum=all ones for exactly that cycle.
  - Next state is FEED if k_len≠0, else WAIT.
- FEED:
  - op_ready=1.
  - On a fire cycle: a_out=op_a and w_out=op_w, combinationally. On any other cycle a_out and w_out are 0 (bubble).
  - The beat counter increments on fire. On the fire with count==K-1, next state is WAIT.
  - Bubbles are legal at any point and do not lose alignment.
- vsr:
  - vsr is 2N bits.
  - vsr[0] = fire, combinational. vsr[n] = registered vsr[n-1].
  - en_mult bit i*N+j = vsr[i+j]. en_accum bit i*N+j = vsr[i+j+1].
  - This matches the array's skew: PE(i,j) sees beat k i+j cycles after it is fed. The accumulator updates one cycle after the product.
- Outside FEED, op_ready=0.
- WAIT: remain in WAIT while vsr≠0, then go to CAPTURE.
- CAPTURE: latch all of c_in into the N*N×DW buffer in one cycle; next state is DRAIN.
- DRAIN:
  - res_valid=1. res_data/res_idx come from the buffer in row-major order (0,0),(0,1),…,(N-1,N-1).
  - The index advances only on res_valid&res_ready. res_data and res_idx must hold stable while res_valid&!res_ready.
  - On the last handshake: done=1 in the following cycle, state IDLE, res_valid=0.
- start while busy is ignored. There is no job overlap.
- Arithmetic is performed in the PEs only. This block passes data through and never modifies it.
- Reset asserted mid-job returns everything to reset values immediately. The job is discarded and no done pulse is produced.
- Latency with no bubbles and res_ready=1: first res_valid occurs K+2N+2 cycles after the start cycle. Total job length is K+2N+1+N*N cycles plus the done cycle.

Test Plan:
- Basic job: N=2, A=[[1,2],[3,4]], W=[[5,6],[7,8]], K=2, no bubbles, res_ready=1.
  - Beats: (a=(1,3), w=(5,6)), then (a=(2,4), w=(7,8)).
  - Required: res stream 19,22,43,50 with idx 00,01,10,11, then one done pulse. The start cycle has clr_* = 4'b1111.
- Bubble insertion: same job with op_valid low for 3 cycles between the two beats.
  - Required: identical results. en_mult shows two separate single-cycle windows per PE, offset by i+j.
- Control alignment check on a fire at cycle T:
  - en_mult[0] at T; en_mult[1] and en_mult[2] at T+1; en_mult[3] at T+2.
  - en_accum bits are each one cycle later than the matching en_mult bits.
- Back-pressure: res_ready toggles 1,0,0,1,…
  - Required: res_data holds 22 through the stall cycles. There are exactly 4 handshakes and done fires once.
- k_len=0: no operand beats are accepted (op_ready stays 0). Result stream is 0,0,0,0.
- Edge cases:
  - start asserted during DRAIN is ignored: busy stays 1 and no clr pulse is generated.
  - rst_n dropped in FEED: all outputs are 0 asynchronously. Afterwards a fresh job completes correctly.
